// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and note-frequency constants for the melody scheduler
package music_pkg;

    typedef struct packed {
        logic [15:0] freq;
        logic [7:0]  dur;
    } note_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } sched_state_t;

    localparam logic [7:0] END_DUR = 8'd0;

    // Frequency codes are the note pitch in Hz
    localparam logic [15:0] NOTE_C4 = 16'd262;
    localparam logic [15:0] NOTE_D4 = 16'd294;
    localparam logic [15:0] NOTE_E4 = 16'd330;
    localparam logic [15:0] NOTE_F4 = 16'd349;
    localparam logic [15:0] NOTE_G4 = 16'd392;
    localparam logic [15:0] NOTE_A4 = 16'd440;
    localparam logic [15:0] NOTE_B4 = 16'd494;
    localparam logic [15:0] NOTE_C5 = 16'd523;

endpackage

// File: rtl/beat_ticker.sv
// rtl/beat_ticker.sv - one-cycle beat pulse every TICK_DIV clocks, restartable via clr
module beat_ticker #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A cleared divider yields its first pulse exactly TICK_DIV cycles after clr drops
    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - melody ROM sequencer with beat timing, note gaps and live-key override
module note_scheduler
    import music_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       key_freq,
    input  logic              key_on,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [15:0]       freq,
    output logic              tone_en,
    output logic              playing,
    output logic [ADDR_W-1:0] note_idx
);

    sched_state_t state;
    note_entry_t  entry;
    logic [15:0]  note_freq;
    logic [7:0]   dur_cnt;
    logic [15:0]  gap_cnt;
    logic         tick;
    logic         beat;
    logic         last_addr;

    assign entry     = rom_data;
    assign beat      = tick && !key_on;
    assign last_addr = &rom_addr;
    assign playing   = (state != S_IDLE);

    beat_ticker #(
        .TICK_DIV (TICK_DIV)
    ) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_IDLE),
        .tick (tick)
    );

    // freq/tone_en are computed from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            note_idx  <= '0;
            note_freq <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            freq      <= '0;
            tone_en   <= 1'b0;
        end else begin
            freq    <= '0;
            tone_en <= 1'b0;
            if (play_stop) begin
                state    <= S_IDLE;
                rom_addr <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play_start) begin
                            state    <= S_FETCH;
                            rom_addr <= '0;
                        end
                    end
                    S_FETCH: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (entry.dur == END_DUR) begin
                            if (loop_en) begin
                                rom_addr <= '0;
                                state    <= S_FETCH;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            note_freq <= entry.freq;
                            dur_cnt   <= entry.dur;
                            note_idx  <= rom_addr;
                            state     <= S_PLAY;
                            freq      <= entry.freq;
                            tone_en   <= |entry.freq;
                        end
                    end
                    S_PLAY: begin
                        if (beat && dur_cnt == 8'd1) begin
                            dur_cnt <= '0;
                            if (GAP_TICKS > 0) begin
                                gap_cnt <= 16'(GAP_TICKS);
                                state   <= S_GAP;
                            end else if (!last_addr) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= S_FETCH;
                            end else if (loop_en) begin
                                rom_addr <= '0;
                                state    <= S_FETCH;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            if (beat) begin
                                dur_cnt <= dur_cnt - 8'd1;
                            end
                            freq    <= note_freq;
                            tone_en <= |note_freq;
                        end
                    end
                    S_GAP: begin
                        if (beat) begin
                            if (gap_cnt == 16'd1) begin
                                gap_cnt <= '0;
                                if (!last_addr) begin
                                    rom_addr <= rom_addr + ADDR_W'(1);
                                    state    <= S_FETCH;
                                end else if (loop_en) begin
                                    rom_addr <= '0;
                                    state    <= S_FETCH;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                gap_cnt <= gap_cnt - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
            if (key_on) begin
                freq    <= key_freq;
                tone_en <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - directed table-driven bench for note_scheduler
module tb_note_scheduler;
    import music_pkg::*;

    localparam int ADDR_W = 2;
    localparam int NS     = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       key_freq = 16'h01ee;
    logic              key_on = 1'b0;
    logic              play_start = 1'b0;
    logic              play_stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic [15:0]       freq;
    logic              tone_en;
    logic              playing;
    logic [ADDR_W-1:0] note_idx;

    logic [23:0] rom [0:3];

    note_scheduler #(
        .ADDR_W    (ADDR_W),
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_freq   (key_freq),
        .key_on     (key_on),
        .play_start (play_start),
        .play_stop  (play_stop),
        .loop_en    (loop_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .freq       (freq),
        .tone_en    (tone_en),
        .playing    (playing),
        .note_idx   (note_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        int          scn;
        int          lo;
        int          hi;
        logic [15:0] f;
        logic        en;
        logic        pl;
    } exp_t;

    exp_t tbl[$];

    logic [15:0]       s_freq [0:NS-1];
    logic              s_en   [0:NS-1];
    logic              s_pl   [0:NS-1];
    logic [ADDR_W-1:0] s_addr [0:NS-1];
    logic [ADDR_W-1:0] s_idx  [0:NS-1];

    int tests = 0;
    int fails = 0;

    function automatic void add(input int scn, input int lo, input int hi,
                                input logic [15:0] f, input logic en, input logic pl);
        exp_t e;
        e.scn = scn; e.lo = lo; e.hi = hi; e.f = f; e.en = en; e.pl = pl;
        tbl.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        play_start = 1'b0;
        play_stop = 1'b0;
        key_on = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Cycle 0 is the cycle in which play_start is presented
    task automatic run_scn(input int n, input int stop_c, input int rst_c,
                           input int kon_lo, input int kon_hi);
        for (int c = 0; c < n; c++) begin
            s_freq[c] = freq;
            s_en[c]   = tone_en;
            s_pl[c]   = playing;
            s_addr[c] = rom_addr;
            s_idx[c]  = note_idx;
            play_start = (c == 0);
            play_stop  = (c == stop_c);
            rst        = (c == rst_c);
            key_on     = (c >= kon_lo && c <= kon_hi);
            step();
        end
        play_start = 1'b0;
        play_stop = 1'b0;
        rst = 1'b0;
        key_on = 1'b0;
    endtask

    task automatic check_table(input int scn, input string name);
        foreach (tbl[i]) begin
            if (tbl[i].scn == scn) begin
                int bad;
                bad = -1;
                for (int c = tbl[i].lo; c <= tbl[i].hi; c++) begin
                    if (bad < 0 && (s_freq[c] !== tbl[i].f || s_en[c] !== tbl[i].en ||
                                    s_pl[c] !== tbl[i].pl))
                        bad = c;
                end
                tests++;
                if (bad >= 0) begin
                    fails++;
                    $display("FAIL %s cycles %0d-%0d at cyc %0d: got freq=%h tone_en=%b playing=%b, want freq=%h tone_en=%b playing=%b",
                             name, tbl[i].lo, tbl[i].hi, bad, s_freq[bad], s_en[bad], s_pl[bad],
                             tbl[i].f, tbl[i].en, tbl[i].pl);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        // 1: basic two-note song
        add(1, 0, 0, 16'h0000, 1'b0, 1'b0);
        add(1, 1, 2, 16'h0000, 1'b0, 1'b1);
        add(1, 3, 8, 16'h0106, 1'b1, 1'b1);
        add(1, 9, 14, 16'h0000, 1'b0, 1'b1);
        add(1, 15, 16, 16'h0115, 1'b1, 1'b1);
        add(1, 17, 22, 16'h0000, 1'b0, 1'b1);
        add(1, 23, 24, 16'h0000, 1'b0, 1'b0);
        // 2: looping replays the first note
        add(2, 15, 16, 16'h0115, 1'b1, 1'b1);
        add(2, 17, 24, 16'h0000, 1'b0, 1'b1);
        add(2, 25, 32, 16'h0106, 1'b1, 1'b1);
        add(2, 33, 34, 16'h0000, 1'b0, 1'b1);
        // 3: live key held cycles 5..14 pauses the melody
        add(3, 3, 5, 16'h0106, 1'b1, 1'b1);
        add(3, 6, 15, 16'h01ee, 1'b1, 1'b1);
        add(3, 16, 16, 16'h0106, 1'b1, 1'b1);
        add(3, 17, 22, 16'h0000, 1'b0, 1'b1);
        add(3, 23, 24, 16'h0115, 1'b1, 1'b1);
        add(3, 25, 30, 16'h0000, 1'b0, 1'b1);
        add(3, 31, 32, 16'h0000, 1'b0, 1'b0);
        // 4: stop during the second note
        add(4, 3, 8, 16'h0106, 1'b1, 1'b1);
        add(4, 15, 15, 16'h0115, 1'b1, 1'b1);
        add(4, 16, 19, 16'h0000, 1'b0, 1'b0);
        // 5: rest entry
        add(5, 1, 14, 16'h0000, 1'b0, 1'b1);
        add(5, 15, 16, 16'h0115, 1'b1, 1'b1);
        add(5, 17, 22, 16'h0000, 1'b0, 1'b1);
        add(5, 23, 23, 16'h0000, 1'b0, 1'b0);
        // 6: full 4-entry ROM ends after address 3
        add(6, 3, 4, NOTE_C4, 1'b1, 1'b1);
        add(6, 5, 10, 16'h0000, 1'b0, 1'b1);
        add(6, 11, 12, NOTE_D4, 1'b1, 1'b1);
        add(6, 13, 18, 16'h0000, 1'b0, 1'b1);
        add(6, 19, 20, NOTE_E4, 1'b1, 1'b1);
        add(6, 21, 26, 16'h0000, 1'b0, 1'b1);
        add(6, 27, 28, NOTE_F4, 1'b1, 1'b1);
        add(6, 29, 32, 16'h0000, 1'b0, 1'b1);
        add(6, 33, 34, 16'h0000, 1'b0, 1'b0);
        // 7: reset during the second note's PLAY
        add(7, 11, 11, NOTE_D4, 1'b1, 1'b1);
        add(7, 12, 14, 16'h0000, 1'b0, 1'b0);

        rom[0] = {16'h0106, 8'd2};
        rom[1] = {16'h0115, 8'd1};
        rom[2] = {16'h0000, 8'd0};
        rom[3] = {16'h0000, 8'd0};

        do_reset();
        chk("reset freq", freq, 16'h0000);
        chk("reset tone_en", 16'(tone_en), 16'h0000);
        chk("reset playing", 16'(playing), 16'h0000);
        chk("reset rom_addr", 16'(rom_addr), 16'h0000);
        chk("reset note_idx", 16'(note_idx), 16'h0000);

        run_scn(25, -1, -1, -1, -1);
        check_table(1, "song");
        chk("song note_idx second", 16'(s_idx[15]), 16'h0001);

        do_reset();
        loop_en = 1'b1;
        run_scn(35, -1, -1, -1, -1);
        loop_en = 1'b0;
        check_table(2, "loop");
        chk("loop rom_addr at end", 16'(s_addr[21]), 16'h0002);
        chk("loop rom_addr rewound", 16'(s_addr[23]), 16'h0000);
        chk("loop note_idx replay", 16'(s_idx[25]), 16'h0000);

        do_reset();
        run_scn(33, -1, -1, 5, 14);
        check_table(3, "key override");

        do_reset();
        run_scn(20, 15, -1, -1, -1);
        check_table(4, "stop");
        chk("stop rom_addr before", 16'(s_addr[15]), 16'h0001);
        chk("stop rom_addr after", 16'(s_addr[16]), 16'h0000);
        play_start = 1'b1;
        play_stop = 1'b1;
        step();
        play_start = 1'b0;
        play_stop = 1'b0;
        chk("start+stop playing", 16'(playing), 16'h0000);
        step();
        chk("start+stop still idle", 16'(playing), 16'h0000);

        do_reset();
        rom[0] = {16'h0000, 8'd2};
        run_scn(24, -1, -1, -1, -1);
        check_table(5, "rest");
        chk("rest note_idx", 16'(s_idx[3]), 16'h0000);

        do_reset();
        rom[0] = {NOTE_C4, 8'd1};
        rom[1] = {NOTE_D4, 8'd1};
        rom[2] = {NOTE_E4, 8'd1};
        rom[3] = {NOTE_F4, 8'd1};
        run_scn(35, -1, -1, -1, -1);
        check_table(6, "full rom");
        chk("full rom last addr", 16'(s_addr[27]), 16'h0003);
        chk("full rom last note_idx", 16'(s_idx[27]), 16'h0003);

        do_reset();
        run_scn(15, -1, 11, -1, -1);
        check_table(7, "mid reset");
        chk("mid reset rom_addr", 16'(s_addr[12]), 16'h0000);
        chk("mid reset note_idx", 16'(s_idx[12]), 16'h0000);
        chk("mid reset note_idx before", 16'(s_idx[11]), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequences the tone generator between live keyboard notes and an autoplay melody stored in a synchronous note ROM. The block fetches {freq, duration} entries, times each note in beat ticks, inserts an articulation gap between notes, and lets live keys override the melody. It sits between the keyboard front end (key frequency plus note-on) and the square-wave tone generator. Its `freq` / `tone_en` pair replaces the keyboard's direct `freq` / `reset` drive.

## Interface
Parameters:
- `ADDR_W`, 8: note ROM address width; the song holds at most 2^ADDR_W entries.
- `TICK_DIV`, 12_500_000: clk cycles per beat tick (0.25 s at 50 MHz); must be ≥2.
- `GAP_TICKS`, 1: silent ticks between melody notes; 0 means no gap.

Ports:
- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `key_freq`, in, 16: live note frequency code from the keyboard decoder.
- `key_on`, in, 1: live key held (the keyboard's note-active flag).
- `play_start`, in, 1: level or pulse; sampled each cycle.
- `play_stop`, in, 1: level or pulse; sampled each cycle.
- `loop_en`, in, 1: restart the song at address 0 on end-of-song.
- `rom_addr`, out, ADDR_W: note ROM read address (registered).
- `rom_data`, in, 24: {freq[23:8], dur[7:0]}, valid one cycle after `rom_addr`.
- `freq`, out, 16: frequency code to the tone generator (registered).
- `tone_en`, out, 1: tone generator enable (registered).
- `playing`, out, 1: melody active (any state except IDLE).
- `note_idx`, out, ADDR_W: address of the note currently sounding, for the hex display.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: `play_start`=1 and `play_stop`=0 → FETCH. Also sets `rom_addr`=0 and clears the tick divider.
- FETCH: drives `rom_addr`. Next state is always LOAD.
- LOAD: captures `rom_data`.
  - If dur==0, this is end-of-song.
  - Otherwise `note_freq`←freq, `dur_cnt`←dur, `note_idx`←`rom_addr`, and → PLAY.
- PLAY: on each tick, `dur_cnt`−1.
  - On the tick where `dur_cnt`==1: → GAP if GAP_TICKS>0, else advance.
- GAP: `gap_cnt` is loaded with GAP_TICKS on entry and counts ticks down. When it expires, advance.
- Advance:
  - If `rom_addr`==all-ones, this is end-of-song.
  - Otherwise `rom_addr`+1 and → FETCH.
- End-of-song:
  - `loop_en`=1: `rom_addr`←0 and → FETCH.
  - `loop_en`=0: → IDLE.
- Rest entry (freq==0, dur≠0): timed exactly like a note, with `tone_en`=0.
- Live override: while `key_on`=1, `freq`←`key_freq` and `tone_en`←1. Tick decrements in PLAY and GAP are suppressed, so the melody pauses and resumes when the key is released.
- Output mux priority, lowest to highest:
  - Melody PLAY with `note_freq`≠0 → `freq`=`note_freq`, `tone_en`=1.
  - Otherwise → `freq`=0, `tone_en`=0.
  - `key_on` overrides both of the above.
- `play_stop`=1 in any state → IDLE next cycle, `rom_addr`←0, melody silenced. Live keys still pass through.
- `play_start` and `play_stop` asserted together: stop wins.
- `play_start` while not IDLE: ignored.

## Timing
- Reset values: `freq`=0, `tone_en`=0, `playing`=0, `rom_addr`=0, `note_idx`=0, state=IDLE, all counters 0.
- `rst` asserted mid-song: all of the above take effect on the next edge. No note completes.
- Start latency: `play_start` sampled in cycle 0 → FETCH in cycle 1 → LOAD in cycle 2 → `freq`/`tone_en` valid in cycle 3.
- Inter-note latency without a gap: 2 cycles of FETCH/LOAD with the tone silenced, then the new note.
- Tick: a one-cycle pulse every TICK_DIV cycles. The divider is restarted on the IDLE→FETCH transition, so the first tick arrives TICK_DIV cycles after start.
- Note length: dur ticks exactly, measured from PLAY entry, plus the partial tick phase.
- Live override latency: one cycle from a `key_on` or `key_freq` change to `freq`.
- A tick coinciding with `key_on`=1 is lost, not deferred.

## Structure
- Package `music_pkg`:
  - `note_entry_t` struct {freq 16, dur 8}.
  - `sched_state_t` enum.
  - `END_DUR` = 8'd0.
  - Shared 16-bit frequency-code constants for the C-major scale.
- Sub-module `beat_ticker`, parameter TICK_DIV; ports `clk`, `rst`, `clr`, output `tick`.
- FSM, counters and output mux live in `note_scheduler`.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=1 and a behavioural 1-cycle ROM.

1. ROM[0]={0x0106,2}, ROM[1]={0x0115,1}, ROM[2]={x,0}; pulse `play_start`.
   - `freq`=0x0106 from cycle 3 for 2 ticks, then silent for 1 tick.
   - Then `freq`=0x0115 for 1 tick, silent for 1 tick.
   - Then IDLE with `playing`=0.
2. Same ROM with `loop_en`=1 → after ROM[1] and its gap, `rom_addr` returns to 0 and 0x0106 replays.
3. Hold `key_on`=1, `key_freq`=0x01ee for 10 cycles mid-note.
   - `freq`=0x01ee one cycle after assertion.
   - Melody note resumes afterwards with its remaining ticks intact.
4. `play_stop` pulsed during PLAY → IDLE next cycle, `tone_en`=0, `rom_addr`=0. `play_start`+`play_stop` together from IDLE → remains IDLE.
5. ROM entry {0x0000,2} → `tone_en`=0 for 2 ticks, then the next note sounds on schedule.
6. ADDR_W=2 with all 4 entries dur≠0 → after address 3, end-of-song (IDLE); `rst` mid-PLAY → all reset values next cycle.
